// File: rtl/dmem_if.sv
// Load/store handshake between the MEM stage and the data-memory responder.
// The requester drives the request fields and the responder drives the rest.
interface dmem_if;
    logic        req_valid_i;
    logic        req_we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        req_ready_o;
    logic        resp_valid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output req_valid_i,
        output req_we_i,
        output addr_i,
        output wdata_i,
        input  req_ready_o,
        input  resp_valid_o,
        input  rdata_o,
        input  err_o,
        input  stall_o
    );

    modport slave (
        input  req_valid_i,
        input  req_we_i,
        input  addr_i,
        input  wdata_i,
        output req_ready_o,
        output resp_valid_o,
        output rdata_o,
        output err_o,
        output stall_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency word data memory for the MEM stage.
// Holds the pipeline stalled until the single outstanding access responds.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input logic   clk_i,
    input logic   rst_i,
    dmem_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            mis_q, mis_d;
    logic            we_q, we_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            enter_resp;
    logic [AW-1:0]   c_idx;
    logic            c_mis;
    logic            c_we;
    logic [31:0]     c_wdata;
    logic            unused_addr;

    assign unused_addr = ^bus.addr_i[31:AW+2];

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        mis_d      = mis_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    idx_d   = bus.addr_i[AW+1:2];
                    mis_d   = |bus.addr_i[1:0];
                    we_d    = bus.req_we_i;
                    wdata_d = bus.wdata_i;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                        count_d = CW'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With LATENCY=1 the commit edge is the acceptance edge, so use live inputs
    always_comb begin
        if (state_q == IDLE) begin
            c_idx   = bus.addr_i[AW+1:2];
            c_mis   = |bus.addr_i[1:0];
            c_we    = bus.req_we_i;
            c_wdata = bus.wdata_i;
        end else begin
            c_idx   = idx_q;
            c_mis   = mis_q;
            c_we    = we_q;
            c_wdata = wdata_q;
        end
    end

    always_comb begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (enter_resp) begin
            err_d = c_mis;
            if (!c_mis && !c_we) begin
                rdata_d = mem[c_idx];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is not reset; a reset on the commit edge drops the store
    always_ff @(posedge clk_i) begin
        if (!rst_i && enter_resp && c_we && !c_mis) begin
            mem[c_idx] <= c_wdata;
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.resp_valid_o = (state_q == RESP);
    assign bus.rdata_o      = rdata_q;
    assign bus.err_o        = err_q;
    assign bus.stall_o      = ((state_q == IDLE) && bus.req_valid_i) ||
                              (state_q == BUSY);
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized check of dmem_responder against a word-array reference model.
// Covers latency 2 (main instance) and latency 1 (back-to-back instance).
module tb_dmem_responder;
    localparam int DEPTH = 128;
    localparam int LAT   = 2;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] mem_m [DEPTH];
    bit          known [DEPTH];

    dmem_if a ();
    dmem_if b ();

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(1)) u_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic xact(input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata);
        int unsigned idx;
        bit          mis;
        bit          rd_known;
        logic [31:0] exp_rd;
        int          n;
        bit          got;
        idx      = (addr / 4) % DEPTH;
        mis      = (addr % 4) != 0;
        rd_known = we || mis || known[idx];
        exp_rd   = (we || mis) ? 32'h0 : mem_m[idx];
        got      = 1'b0;
        n        = 0;
        @(negedge clk);
        a.req_valid_i = 1'b1;
        a.req_we_i    = we;
        a.addr_i      = addr;
        a.wdata_i     = wdata;
        #1;
        check("ready_acc", a.req_ready_o, 1);
        check("stall_acc", a.stall_o, 1);
        while (!got && n < LAT + 3) begin
            @(negedge clk);
            n++;
            if (a.resp_valid_o) begin
                got = 1'b1;
            end else begin
                check("stall_busy", a.stall_o, 1);
                check("rdata_busy", a.rdata_o, 0);
            end
        end
        check("resp_seen", got, 1);
        if (got) begin
            check("latency", n, LAT);
            check("err", a.err_o, mis);
            if (rd_known) check("rdata", a.rdata_o, exp_rd);
            check("stall_resp", a.stall_o, 0);
            check("ready_resp", a.req_ready_o, 0);
        end
        a.req_valid_i = 1'b0;
        @(negedge clk);
        check("ready_after", a.req_ready_o, 1);
        check("rv_after", a.resp_valid_o, 0);
        check("rdata_after", a.rdata_o, 0);
        check("err_after", a.err_o, 0);
        if (we && !mis) begin
            mem_m[idx] = wdata;
            known[idx] = 1'b1;
        end
    endtask

    initial begin
        logic [31:0] ad;
        checks = 0;
        errors = 0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
        rst = 1'b1;
        a.req_valid_i = 1'b0;
        a.req_we_i    = 1'b0;
        a.addr_i      = '0;
        a.wdata_i     = '0;
        b.req_valid_i = 1'b0;
        b.req_we_i    = 1'b0;
        b.addr_i      = '0;
        b.wdata_i     = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", a.req_ready_o, 1);
        check("rst_rv", a.resp_valid_o, 0);
        check("rst_rdata", a.rdata_o, 0);
        check("rst_err", a.err_o, 0);
        check("rst_stall", a.stall_o, 0);
        rst = 1'b0;

        // directed: store, load, misaligned, wrap
        xact(1'b1, 32'h10, 32'hDEADBEEF);
        xact(1'b0, 32'h10, 32'h0);
        check("lw10", mem_m[4], 32'hDEADBEEF);
        xact(1'b1, 32'h13, 32'h12345678);
        xact(1'b0, 32'h10, 32'h0);
        xact(1'b1, 32'h200, 32'hA5A5A5A5);
        xact(1'b0, 32'h000, 32'h0);
        xact(1'b0, 32'h11, 32'h0);

        // reset during BUSY drops the store
        xact(1'b1, 32'h20, 32'hCAFE0000);
        @(negedge clk);
        a.req_valid_i = 1'b1;
        a.req_we_i    = 1'b1;
        a.addr_i      = 32'h20;
        a.wdata_i     = 32'h1;
        @(negedge clk);
        check("busy_before_rst", a.stall_o, 1);
        rst = 1'b1;
        a.req_valid_i = 1'b0;
        @(negedge clk);
        check("rst_no_resp", a.resp_valid_o, 0);
        check("rst_idle", a.req_ready_o, 1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rv", a.resp_valid_o, 0);
        xact(1'b0, 32'h20, 32'h0);

        // randomized traffic over a small window plus random high bits
        for (int i = 0; i < 60; i++) begin
            ad = $urandom_range(0, 63) * 4;
            if ($urandom_range(0, 3) == 0) ad = ad + $urandom_range(1, 3);
            if ($urandom_range(0, 3) == 0) ad = ad | ($urandom << 9);
            xact($urandom_range(0, 1) == 1, ad, $urandom);
        end

        // latency 1: prime a word, then hold three loads continuously
        @(negedge clk);
        b.req_valid_i = 1'b1;
        b.req_we_i    = 1'b1;
        b.addr_i      = 32'h40;
        b.wdata_i     = 32'h11111111;
        @(negedge clk);
        check("b_sw_resp", b.resp_valid_o, 1);
        check("b_sw_rdata", b.rdata_o, 0);
        b.req_valid_i = 1'b0;
        @(negedge clk);
        b.req_valid_i = 1'b1;
        b.req_we_i    = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("b_stall", b.stall_o, (i % 2 == 0) ? 1 : 0);
            check("b_rv", b.resp_valid_o, (i % 2 == 1) ? 1 : 0);
            if (i % 2 == 1) check("b_rdata", b.rdata_o, 32'h11111111);
        end
        b.req_valid_i = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
